// File: rtl/expand_core_cxy_pkg.sv
// Shared constants and FSM encoding for the 3x pixel-replicating expander.
package expand_core_cxy_pkg;

  localparam int unsigned IN_W   = 64;
  localparam int unsigned IN_H   = 64;
  localparam int unsigned SCALE  = 3;
  localparam int unsigned OUT_W  = IN_W * SCALE;
  localparam int unsigned OUT_H  = IN_H * SCALE;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DEPTH  = IN_W * IN_H;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/bit_frame_buf_cxy.sv
// One-bit-wide frame store: synchronous write port, registered read port.
module bit_frame_buf_cxy
  import expand_core_cxy_pkg::*;
#(
  parameter int unsigned P_DEPTH = DEPTH,
  parameter int unsigned P_AW    = ADDR_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [P_AW-1:0] wr_addr,
  input  logic            wr_data,
  input  logic            rd_en,
  input  logic [P_AW-1:0] rd_addr,
  output logic            rd_data
);

  logic mem [P_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Only the read register is reset; the array keeps its contents.
  always_ff @(posedge clk) begin
    if (!rst_n)     rd_data <= 1'b0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/expand_core_cxy.sv
// Buffers one binary frame, then replays it with every pixel replicated into a
// P_SCALE x P_SCALE block, one output pixel per accepted OUT_READY.
module expand_core_cxy
  import expand_core_cxy_pkg::*;
#(
  parameter int unsigned P_IN_W  = IN_W,
  parameter int unsigned P_IN_H  = IN_H,
  parameter int unsigned P_SCALE = SCALE
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic DIN_VALID,
  input  logic DIN,
  input  logic DIN_LAST_IN_LINE,
  input  logic DIN_LAST_PIX,
  input  logic OUT_READY,
  output logic OUT,
  output logic VALID,
  output logic LAST_IN_LINE,
  output logic LAST_PIX,
  output logic BUSY,
  output logic FRAME_ERR,
  output logic OVERFLOW
);

  localparam int unsigned OW    = P_IN_W * P_SCALE;
  localparam int unsigned OH    = P_IN_H * P_SCALE;
  localparam int unsigned COL_W = $clog2(P_IN_W);
  localparam int unsigned ROW_W = $clog2(P_IN_H);
  localparam int unsigned AW    = COL_W + ROW_W;
  localparam int unsigned OH_W  = $clog2(OW);
  localparam int unsigned OV_W  = $clog2(OH);
  localparam int unsigned S_W   = $clog2(P_SCALE);

  state_t state, state_nxt;

  logic [COL_W-1:0] wr_col, src_col;
  logic [ROW_W-1:0] wr_row, src_row;
  logic [OH_W-1:0]  out_h;
  logic [OV_W-1:0]  out_v;
  logic [S_W-1:0]   sh, sv;

  logic wr_en_c, rd_en_c, fill_done_c, drain_done_c, err_c;
  logic col_end_c, wr_last_c, h_end_c, v_end_c, sh_end_c, sv_end_c;

  assign col_end_c = (wr_col == COL_W'(P_IN_W - 1));
  assign wr_last_c = col_end_c && (wr_row == ROW_W'(P_IN_H - 1));
  assign h_end_c   = (out_h == OH_W'(OW - 1));
  assign v_end_c   = (out_v == OV_W'(OH - 1));
  assign sh_end_c  = (sh == S_W'(P_SCALE - 1));
  assign sv_end_c  = (sv == S_W'(P_SCALE - 1));

  always_ff @(posedge CLK) begin
    if (!RSTn) state <= ST_FILL;
    else       state <= state_nxt;
  end

  // Frame ends at the last address or at an upstream LAST_PIX, whichever is first.
  always_comb begin
    state_nxt    = state;
    wr_en_c      = 1'b0;
    rd_en_c      = 1'b0;
    fill_done_c  = 1'b0;
    drain_done_c = 1'b0;
    err_c        = 1'b0;
    case (state)
      ST_FILL: begin
        if (DIN_VALID) begin
          wr_en_c = 1'b1;
          err_c   = (DIN_LAST_IN_LINE && !col_end_c) ||
                    (DIN_LAST_PIX && !wr_last_c) ||
                    (wr_last_c && !DIN_LAST_PIX);
          if (wr_last_c || DIN_LAST_PIX) begin
            fill_done_c = 1'b1;
            state_nxt   = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (OUT_READY) begin
          rd_en_c = 1'b1;
          if (h_end_c && v_end_c) begin
            drain_done_c = 1'b1;
            state_nxt    = ST_FILL;
          end
        end
      end
      default: state_nxt = ST_FILL;
    endcase
  end

  // Flags and counters; source coordinates step every P_SCALE outputs.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      VALID        <= 1'b0;
      LAST_IN_LINE <= 1'b0;
      LAST_PIX     <= 1'b0;
      BUSY         <= 1'b0;
      FRAME_ERR    <= 1'b0;
      OVERFLOW     <= 1'b0;
      wr_col       <= '0;
      wr_row       <= '0;
      out_h        <= '0;
      out_v        <= '0;
      sh           <= '0;
      sv           <= '0;
      src_col      <= '0;
      src_row      <= '0;
    end else begin
      VALID        <= rd_en_c;
      LAST_IN_LINE <= rd_en_c && h_end_c;
      LAST_PIX     <= drain_done_c;
      BUSY         <= (state_nxt == ST_DRAIN);
      if (err_c) FRAME_ERR <= 1'b1;
      if (state == ST_DRAIN && DIN_VALID) OVERFLOW <= 1'b1;

      if (fill_done_c) begin
        wr_col <= '0;
        wr_row <= '0;
      end else if (wr_en_c) begin
        if (col_end_c) begin
          wr_col <= '0;
          wr_row <= wr_row + 1'b1;
        end else begin
          wr_col <= wr_col + 1'b1;
        end
      end

      if (drain_done_c) begin
        out_h   <= '0;
        out_v   <= '0;
        sh      <= '0;
        sv      <= '0;
        src_col <= '0;
        src_row <= '0;
      end else if (rd_en_c) begin
        if (h_end_c) begin
          out_h   <= '0;
          sh      <= '0;
          src_col <= '0;
          out_v   <= out_v + 1'b1;
          if (sv_end_c) begin
            sv      <= '0;
            src_row <= src_row + 1'b1;
          end else begin
            sv <= sv + 1'b1;
          end
        end else begin
          out_h <= out_h + 1'b1;
          if (sh_end_c) begin
            sh      <= '0;
            src_col <= src_col + 1'b1;
          end else begin
            sh <= sh + 1'b1;
          end
        end
      end
    end
  end

  bit_frame_buf_cxy #(
    .P_DEPTH (P_IN_W * P_IN_H),
    .P_AW    (AW)
  ) u_buf (
    .clk     (CLK),
    .rst_n   (RSTn),
    .wr_en   (wr_en_c),
    .wr_addr ({wr_row, wr_col}),
    .wr_data (DIN),
    .rd_en   (rd_en_c),
    .rd_addr ({src_row, src_col}),
    .rd_data (OUT)
  );

endmodule
